// File: rtl/logic_analyzer_cmd_rx.sv
// Host-command receiver: parses 0xA5-headed command frames from the UART and drives analyzer config/trigger.
// Define LA_CMD_CHECKSUM_EN for 5-byte frames with a trailing checksum; otherwise frames are 4 bytes.
module logic_analyzer_cmd_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [15:0] DIV_CNT_RST    = 16'd49,
  parameter logic [11:0] DEPTH_RST      = 12'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_done,
  input  logic [7:0]  uart_rx_data,
  output logic        trigger,
  output logic [1:0]  trigger_ch,
  output logic        edge_type,
  output logic        en0,
  output logic        en1,
  output logic        en2,
  output logic        en3,
  output logic [15:0] div_cnt,
  output logic [11:0] sample_depth,
  output logic        cmd_ok,
  output logic        cmd_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_CSUM,
    ST_EXEC
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic [7:0]       r_addr, r_dhi, r_dlo;
  logic             w_active, w_tmo_hit, w_tmo_expire;
  logic             w_csum_ok;
  logic [15:0]      w_data;

  logic             r_trigger, r_edge, r_ok, r_err;
  logic [1:0]       r_trig_ch;
  logic [3:0]       r_en;
  logic [15:0]      r_div;
  logic [11:0]      r_depth;

  logic             w_trigger, w_edge_nxt, w_ok, w_err;
  logic [1:0]       w_ch_nxt;
  logic [3:0]       w_en_nxt;
  logic [15:0]      w_div_nxt;
  logic [11:0]      w_depth_nxt;

  // The timeout only runs while a frame is partially received.
  assign w_active     = (r_state != ST_IDLE) && (r_state != ST_EXEC);
  assign w_tmo_hit    = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign w_tmo_expire = w_active && !uart_rx_done && w_tmo_hit;
  assign w_tmo_nxt    = (w_active && !uart_rx_done && !w_tmo_hit) ? r_tmo_cnt + 1'b1 : '0;
  assign w_data       = {r_dhi, r_dlo};

`ifdef LA_CMD_CHECKSUM_EN
  logic [7:0] r_csum;
  logic [7:0] w_sum;
  assign w_sum     = r_addr + r_dhi + r_dlo;
  assign w_csum_ok = (w_sum == r_csum);
`else
  assign w_csum_ok = 1'b1;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (uart_rx_done && uart_rx_data == 8'hA5) w_state_nxt = ST_ADDR;
      ST_ADDR: if (uart_rx_done) w_state_nxt = ST_DHI;
      ST_DHI:  if (uart_rx_done) w_state_nxt = ST_DLO;
`ifdef LA_CMD_CHECKSUM_EN
      ST_DLO:  if (uart_rx_done) w_state_nxt = ST_CSUM;
      ST_CSUM: if (uart_rx_done) w_state_nxt = ST_EXEC;
`else
      ST_DLO:  if (uart_rx_done) w_state_nxt = ST_EXEC;
`endif
      ST_EXEC: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_tmo_expire) w_state_nxt = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_nxt;
    end
  end

  // NOTE: payload bytes are reset too; cheap here and keeps the frame buffer free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_dhi  <= '0;
      r_dlo  <= '0;
`ifdef LA_CMD_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else if (uart_rx_done) begin
      case (r_state)
        ST_ADDR: r_addr <= uart_rx_data;
        ST_DHI:  r_dhi  <= uart_rx_data;
        ST_DLO:  r_dlo  <= uart_rx_data;
`ifdef LA_CMD_CHECKSUM_EN
        ST_CSUM: r_csum <= uart_rx_data;
`endif
        default: ;
      endcase
    end
  end

  // Command execution: decided during EXEC, visible one edge later.
  always_comb begin
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_trigger   = 1'b0;
    w_en_nxt    = r_en;
    w_ch_nxt    = r_trig_ch;
    w_edge_nxt  = r_edge;
    w_div_nxt   = r_div;
    w_depth_nxt = r_depth;
    if (r_state == ST_EXEC) begin
      if (!w_csum_ok) begin
        w_err = 1'b1;
      end else begin
        case (r_addr)
          8'h01: begin
            w_en_nxt = w_data[3:0];
            w_ok     = 1'b1;
          end
          8'h02: begin
            w_ch_nxt   = w_data[1:0];
            w_edge_nxt = w_data[2];
            w_ok       = 1'b1;
          end
          8'h03: begin
            w_div_nxt = w_data;
            w_ok      = 1'b1;
          end
          8'h04: begin
            if (w_data[15:12] == 4'd0 && w_data[11:0] != 12'd0) begin
              w_depth_nxt = w_data[11:0];
              w_ok        = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end
          8'h05: begin
            w_trigger = 1'b1;
            w_ok      = 1'b1;
          end
          default: w_err = 1'b1;
        endcase
      end
    end else if (w_tmo_expire) begin
      w_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trigger <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_trig_ch <= 2'd0;
      r_edge    <= 1'b1;
      r_en      <= 4'hF;
      r_div     <= DIV_CNT_RST;
      r_depth   <= DEPTH_RST;
    end else begin
      r_trigger <= w_trigger;
      r_ok      <= w_ok;
      r_err     <= w_err;
      r_trig_ch <= w_ch_nxt;
      r_edge    <= w_edge_nxt;
      r_en      <= w_en_nxt;
      r_div     <= w_div_nxt;
      r_depth   <= w_depth_nxt;
    end
  end

  assign trigger      = r_trigger;
  assign cmd_ok       = r_ok;
  assign cmd_err      = r_err;
  assign trigger_ch   = r_trig_ch;
  assign edge_type    = r_edge;
  assign {en3, en2, en1, en0} = r_en;
  assign div_cnt      = r_div;
  assign sample_depth = r_depth;

endmodule

// File: tb/tb_logic_analyzer_cmd_rx.sv
// Self-checking bench for logic_analyzer_cmd_rx: byte-stream reference model compared every cycle,
// plus directed frames with literal expectations. Honours LA_CMD_CHECKSUM_EN like the design.
module tb_logic_analyzer_cmd_rx;

  localparam int T = 20;
`ifdef LA_CMD_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx_done = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        trigger, edge_type, en0, en1, en2, en3, cmd_ok, cmd_err;
  logic [1:0]  trigger_ch;
  logic [15:0] div_cnt;
  logic [11:0] sample_depth;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 1'b0;

  logic_analyzer_cmd_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .trigger(trigger), .trigger_ch(trigger_ch), .edge_type(edge_type),
    .en0(en0), .en1(en1), .en2(en2), .en3(en3),
    .div_cnt(div_cnt), .sample_depth(sample_depth),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bytes accumulate in a queue; a full frame executes on the following edge.
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_exec;
  logic        e_trig, e_edge, e_ok, e_err;
  logic [1:0]  e_ch;
  logic [3:0]  e_en;
  logic [15:0] e_div;
  logic [11:0] e_depth;

  task automatic model_reset();
    m_q.delete();
    m_idle = 0; m_exec = 0;
    e_trig = 0; e_ok = 0; e_err = 0;
    e_ch = 0; e_edge = 1; e_en = 4'hF; e_div = 16'd49; e_depth = 12'd1024;
  endtask

  task automatic exec_frame();
    logic [7:0]  a;
    logic [15:0] d;
    a = m_q[1];
    d = {m_q[2], m_q[3]};
`ifdef LA_CMD_CHECKSUM_EN
    if (((int'(m_q[1]) + int'(m_q[2]) + int'(m_q[3])) % 256) != int'(m_q[4])) begin
      e_err = 1;
      return;
    end
`endif
    case (a)
      8'h01: begin e_en = d[3:0]; e_ok = 1; end
      8'h02: begin e_ch = d[1:0]; e_edge = d[2]; e_ok = 1; end
      8'h03: begin e_div = d; e_ok = 1; end
      8'h04: begin
        if (d < 16'h1000 && d != 0) begin e_depth = d[11:0]; e_ok = 1; end
        else e_err = 1;
      end
      8'h05: begin e_trig = 1; e_ok = 1; end
      default: e_err = 1;
    endcase
  endtask

  task automatic model_step();
    e_trig = 0; e_ok = 0; e_err = 0;
    if (m_exec) begin
      exec_frame();
      m_q.delete();
      m_exec = 0;
    end else if (uart_rx_done) begin
      if (m_q.size() != 0 || uart_rx_data == 8'hA5) begin
        m_q.push_back(uart_rx_data);
        m_idle = 0;
        if (m_q.size() == FLEN) m_exec = 1;
      end
    end else if (m_q.size() != 0) begin
      if (m_idle == T) begin
        m_q.delete();
        m_idle = 0;
        e_err = 1;
      end else begin
        m_idle++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        check("outputs",
              {trigger, trigger_ch, edge_type, en3, en2, en1, en0, div_cnt, sample_depth, cmd_ok, cmd_err},
              {e_trig, e_ch, e_edge, e_en, e_div, e_depth, e_ok, e_err});
        check("ok_err_exclusive", {63'd0, cmd_ok & cmd_err}, 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    @(negedge clk);
    uart_rx_done = 1'b0;
    @(negedge clk);
  endtask

  // Returns in the cycle where the frame's result pulses are visible.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                          input logic [7:0] cs, input int g);
    send_byte(8'hA5); idle(g);
    send_byte(a);     idle(g);
    send_byte(dh);    idle(g);
    send_byte(dl);
`ifdef LA_CMD_CHECKSUM_EN
    idle(g);
    send_byte(cs);
`else
    if (cs === 8'hxx) idle(0);
`endif
  endtask

  initial begin
    int         err_cnt;
    logic [7:0] fr[$];
    logic [7:0] a, dh, dl, cs;
    int         kind, g, n;

    // Reset defaults
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_cmp = 1'b1;
    check("rst_div_cnt", div_cnt, 49);
    check("rst_sample_depth", sample_depth, 1024);
    check("rst_en", {en3, en2, en1, en0}, 4'hF);
    check("rst_edge_type", edge_type, 1);
    check("rst_pulses", {cmd_ok, cmd_err, trigger}, 3'b000);

    // Divider write
    send_cmd(8'h03, 8'h01, 8'hF3, 8'hF7, 1);
    check("div_ok", cmd_ok, 1);
    check("div_value", div_cnt, 16'h01F3);
    @(negedge clk);
    check("div_ok_one_cycle", cmd_ok, 0);

    // Bad checksum (a legal 4-byte en write when the checksum is compiled out)
    send_cmd(8'h01, 8'h00, 8'h05, 8'h00, 2);
`ifdef LA_CMD_CHECKSUM_EN
    check("badcs_err", {cmd_err, cmd_ok}, 2'b10);
    check("badcs_en", {en3, en2, en1, en0}, 4'hF);
`else
    check("nocs_ok", {cmd_err, cmd_ok}, 2'b01);
    check("nocs_en", {en3, en2, en1, en0}, 4'h5);
`endif
    @(negedge clk);

    // Illegal then legal depth
    send_cmd(8'h04, 8'h10, 8'h00, 8'h14, 0);
    check("depth_bad_err", {cmd_err, cmd_ok}, 2'b10);
    check("depth_bad_val", sample_depth, 1024);
    idle(1);
    send_cmd(8'h04, 8'h0F, 8'hFF, 8'h12, 1);
    check("depth_ok", {cmd_err, cmd_ok}, 2'b01);
    check("depth_val", sample_depth, 12'hFFF);
    idle(1);

    // Noise then trigger
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("noise_quiet", {cmd_ok, cmd_err, trigger}, 3'b000);
    send_cmd(8'h05, 8'h00, 8'h00, 8'h05, 1);
    check("trig_pulse", {trigger, cmd_ok, cmd_err}, 3'b110);
    @(negedge clk);
    check("trig_one_cycle", {trigger, cmd_ok}, 2'b00);

    // 0xA5 in ADDR is an address (unmapped)
    send_cmd(8'hA5, 8'h00, 8'h00, 8'hA5, 1);
    check("a5_addr_err", {cmd_err, cmd_ok}, 2'b10);
    idle(1);

    // Timeout
    send_byte(8'hA5); send_byte(8'h02);
    err_cnt = 0;
    for (int i = 0; i < T + 5; i++) begin
      if (cmd_err) err_cnt++;
      @(negedge clk);
    end
    check("tmo_err_count", err_cnt, 1);
    send_cmd(8'h02, 8'h00, 8'h06, 8'h08, 1);
    check("tmo_recover_ok", cmd_ok, 1);
    check("tmo_recover_ch", trigger_ch, 2);
    check("tmo_recover_edge", edge_type, 1);
    idle(1);

    // Mid-frame reset
    send_cmd(8'h03, 8'h12, 8'h34, 8'h49, 0);
    check("pre_rst_div", div_cnt, 16'h1234);
    idle(1);
    send_byte(8'hA5); send_byte(8'h03);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_div", div_cnt, 49);
    check("mid_rst_depth", sample_depth, 1024);
    check("mid_rst_cfg", {en3, en2, en1, en0, trigger_ch, edge_type}, 7'b1111_00_1);
    check("mid_rst_pulses", {cmd_ok, cmd_err, trigger}, 3'b000);
    idle(2);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h00); send_byte(8'h07); send_byte(8'h0A);
    idle(2);

    // Randomized byte streams
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      fr.delete();
      if (kind == 0) begin
        a = 8'($urandom_range(0, 255));
        fr.push_back(a == 8'hA5 ? 8'h00 : a);
      end else begin
        a  = 8'($urandom_range(0, 6));
        dh = 8'($urandom_range(0, 255));
        dl = 8'($urandom_range(0, 255));
        if (a == 8'h04) begin
          dh = 8'($urandom_range(0, 31));
          if ($urandom_range(0, 3) == 0) begin dh = 8'h00; dl = 8'h00; end
        end
        cs = a + dh + dl;
        if ($urandom_range(0, 9) < 2) cs = cs ^ 8'($urandom_range(1, 255));
        fr.push_back(8'hA5); fr.push_back(a); fr.push_back(dh); fr.push_back(dl);
        if (FLEN == 5) fr.push_back(cs);
        if (kind == 1) begin
          n = $urandom_range(1, FLEN - 1);
          while (fr.size() > n) void'(fr.pop_back());
        end
      end
      foreach (fr[k]) begin
        send_byte(fr[k]);
        if (k != fr.size() - 1) begin
          g = $urandom_range(0, 19);
          if (g == 0) idle(T - 1);
          else if (g == 1) idle(T);
          else idle($urandom_range(0, 2));
        end
      end
      if (kind == 1) idle(T + $urandom_range(0, 3));
      else idle($urandom_range(0, 3));
    end

    idle(T + 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_analyzer_cmd_rx.md
# logic_analyzer_cmd_rx

Host-command receiver for the 4-channel logic analyzer. It consumes bytes from the UART receiver, parses fixed-length command frames, and drives the configuration and trigger inputs of the analyzer top: `trigger`, `trigger_ch`, `edge_type`, `en0..en3`, `div_cnt` and `sample_depth`. It is the host-to-board counterpart of the UART sample-upload path.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: the maximum number of idle clk cycles allowed between bytes of a single frame.
- `DIV_CNT_RST`, default 16'd49: the reset value of `div_cnt`.
- `DEPTH_RST`, default 12'd1024: the reset value of `sample_depth`.
- `clk` in 1: the system clock. It is the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart_rx_done` in 1: a one-cycle pulse meaning `uart_rx_data` is valid.
- `uart_rx_data` in 8: the received byte.
- `trigger` out 1: a one-cycle start pulse.
- `trigger_ch` out 2: the trigger channel.
- `edge_type` out 1: 0 selects falling, 1 selects rising.
- `en0`, `en1`, `en2`, `en3` out 1 each: the channel upload enables.
- `div_cnt` out 16: the sample clock divider.
- `sample_depth` out 12: the number of samples per channel.
- `cmd_ok` out 1: a one-cycle pulse when a frame is accepted and executed.
- `cmd_err` out 1: a one-cycle pulse when a frame is rejected or times out.

## Operation
- **Frame layout:** `0xA5`, ADDR, DHI, DLO, then CSUM. The 16-bit DATA value is {DHI, DLO}.
- **FSM states:**
  - IDLE: any byte other than `0xA5` is discarded silently. A byte equal to `0xA5` moves the FSM to ADDR.
  - ADDR: advances to DHI. There is no header re-sync. A `0xA5` byte received in ADDR is treated as an address.
  - DHI: advances to DLO.
  - DLO: advances to CSUM.
  - CSUM: advances to EXEC.
  - EXEC: lasts exactly one cycle and always returns to IDLE.
- **Checksum:** (ADDR + DHI + DLO) mod 256 must equal CSUM. On a mismatch, `cmd_err` pulses and no register changes.
- **Address map:**
  - `0x01`: {`en3`,`en2`,`en1`,`en0`} ← DATA[3:0].
  - `0x02`: `trigger_ch` ← DATA[1:0]; `edge_type` ← DATA[2].
  - `0x03`: `div_cnt` ← DATA.
  - `0x04`: `sample_depth` ← DATA[11:0]. The write is legal only if DATA[15:12]==0 and DATA[11:0]!=0. Otherwise `cmd_err` pulses and the value is unchanged.
  - `0x05`: `trigger` pulses high for 1 cycle. DATA is ignored.
  - Any other address: `cmd_err` pulses and nothing changes.
- **Unused bits:** DATA bits outside each field are ignored. Their value does not cause an error.
- **Timeout:**
  - The counter runs while the FSM is in any state except IDLE or EXEC.
  - It clears on every `uart_rx_done`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `cmd_err` pulses, and the partial frame is dropped.
  - If `uart_rx_done` arrives in the same cycle as expiry, the byte wins and no timeout occurs.
- **Width rules:** the checksum sum is truncated to 8 bits. The timeout counter is $clog2(`TIMEOUT_CYCLES`+1) bits wide.
- **Mutual exclusion:** `cmd_ok` and `cmd_err` are never high in the same cycle.
- **Error pulse merging:** at most one `cmd_err` pulse is produced per frame.

## Timing
- **Reset values:**
  - `trigger`=0, `cmd_ok`=0, `cmd_err`=0.
  - `trigger_ch`=2'd0, `edge_type`=1.
  - `en0..en3`=1.
  - `div_cnt`=`DIV_CNT_RST`, `sample_depth`=`DEPTH_RST`.
  - FSM=IDLE, timeout counter=0.
- **Latency:** suppose the final frame byte is sampled at edge N.
  - The FSM is in EXEC during cycle N..N+1.
  - At edge N+1, the configuration registers update, and `cmd_ok`, `cmd_err` and `trigger` assert.
  - Those pulses deassert at edge N+2.
- **Outputs:** all outputs are registered. There is no combinational path from `uart_rx_data`.
- **Input assumptions:** `uart_rx_done` pulses are at least 2 cycles apart, which UART byte timing guarantees. A pulse that arrives in EXEC is dropped.
- **Mid-frame reset:** reset asserted mid-frame aborts it immediately. All outputs return to their reset values and no pulse is emitted.
- **Stability:** configuration outputs hold their value between accepted writes.

## Configuration
- `LA_CMD_CHECKSUM_EN` defined: frames are 5 bytes and the CSUM state and check are present.
- `LA_CMD_CHECKSUM_EN` undefined: frames are 4 bytes (`0xA5`, ADDR, DHI, DLO). DLO moves directly to EXEC, and a checksum error can never occur. All latency figures are measured from the last byte of the frame.

## Test plan
- **Reset defaults:** assert `rst_n`=0 and release it. Expect `div_cnt`=49, `sample_depth`=1024, `en0..en3`=1, `edge_type`=1, and `cmd_ok`=`cmd_err`=`trigger`=0.
- **Divider write:** send `A5 03 01 F3 F7`. Expect `cmd_ok` for exactly 1 cycle and `div_cnt`=16'h01F3 one cycle after the last `uart_rx_done`.
- **Bad checksum:** send `A5 01 00 05 00`. Expect `cmd_err` for 1 cycle, no `cmd_ok`, and `en0..en3` still 1111.
- **Illegal depth:** send `A5 04 10 00 14`. Expect `cmd_err` with `sample_depth` unchanged. Then send `A5 04 0F FF 12`. Expect `cmd_ok` and `sample_depth`=12'hFFF.
- **Noise then trigger:** send garbage `00 FF 5A`, then `A5 05 00 00 05`. Expect the garbage to produce no pulse, and the frame to produce `trigger` and `cmd_ok` high in the same single cycle.
- **Timeout and mid-frame reset:**
  - Send `A5 02` and go silent for `TIMEOUT_CYCLES`. Expect one `cmd_err` and the FSM back in IDLE.
  - A following full frame `A5 02 00 06 08` must yield `trigger_ch`=2, `edge_type`=1 and `cmd_ok`.
  - A reset asserted after `A5 03` restores all defaults.
